// File: rtl/rx_iq_fifo_ctrl.sv
// rx_iq_fifo_ctrl: sequencing controller for the rx I/Q FIFO path.
// On start the FIFO is flushed, then prefilled to a mid-band level before
// reads are enabled, so the downstream read pacer starts in its nominal band.
// While streaming, overflow (write into a full FIFO) and starvation (a long
// run of empty cycles) are detected, counted and recovered from automatically.
//
// Ports:
//   clk, rstn    clock, synchronous active-low reset
//   start        single-cycle request to begin streaming
//   stop         single-cycle request to halt streaming (highest priority)
//   clear_cnt    synchronous clear of both event counters
//   data_count   FIFO occupancy
//   full, empty  FIFO flags
//   wren_in      gated FIFO write strobe as seen at the FIFO
//   fifo_in_en   write gate (FILL, RUN)
//   fifo_out_en  read gate (RUN)
//   fifo_flush   FIFO reset, active-high (FLUSH)
//   state        0 IDLE, 1 FLUSH, 2 FILL, 3 RUN
//   running      high in RUN only
//   ovf_cnt      saturating overflow event count
//   starve_cnt   saturating starvation event count
module rx_iq_fifo_ctrl #(
    parameter int unsigned COUNT_W       = 6,
    parameter int unsigned PREFILL       = 16,
    parameter int unsigned FLUSH_CYCLES  = 4,
    parameter int unsigned STARVE_CYCLES = 64,
    parameter int unsigned CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               stop,
    input  logic               clear_cnt,
    input  logic [COUNT_W-1:0] data_count,
    input  logic               full,
    input  logic               empty,
    input  logic               wren_in,
    output logic               fifo_in_en,
    output logic               fifo_out_en,
    output logic               fifo_flush,
    output logic [1:0]         state,
    output logic               running,
    output logic [CNT_W-1:0]   ovf_cnt,
    output logic [CNT_W-1:0]   starve_cnt
);

    localparam int unsigned FLUSH_W = 4;
    localparam int unsigned EMPTY_W = 8;

    localparam logic [FLUSH_W-1:0] FLUSH_LAST  = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [EMPTY_W-1:0] STARVE_LAST = EMPTY_W'(STARVE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] PREFILL_LVL = COUNT_W'(PREFILL);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FILL  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t             st_q;
    state_t             st_nxt;
    logic [FLUSH_W-1:0] flush_q;
    logic [FLUSH_W-1:0] flush_nxt;
    logic [EMPTY_W-1:0] empty_q;
    logic [EMPTY_W-1:0] empty_nxt;
    logic               overflow;
    logic               ovf_evt;
    logic               starve_evt;

    // Saturating event counter step; a clear always wins over an increment.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cur,
                                                  input logic             inc,
                                                  input logic             clr);
        logic [CNT_W-1:0] res;
        res = cur;
        if (clr) begin
            res = '0;
        end else if (inc && (cur != CNT_MAX)) begin
            res = cur + CNT_W'(1);
        end
        return res;
    endfunction

    // A write into a full FIFO only matters while the write gate is open.
    // If full and empty are both set (illegal), overflow still wins.
    assign overflow = wren_in & full & ((st_q == ST_FILL) | (st_q == ST_RUN));

    // Next-state and sequencing-counter logic.
    always_comb begin
        st_nxt     = st_q;
        flush_nxt  = flush_q;
        empty_nxt  = empty_q;
        ovf_evt    = 1'b0;
        starve_evt = 1'b0;

        if (stop) begin
            st_nxt = ST_IDLE;
        end else if (overflow) begin
            ovf_evt   = 1'b1;
            st_nxt    = ST_FLUSH;
            flush_nxt = '0;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    if (start) begin
                        st_nxt    = ST_FLUSH;
                        flush_nxt = '0;
                    end
                end
                ST_FLUSH: begin
                    // flush_q counts 0..FLUSH_CYCLES-1, one FLUSH cycle each
                    if (flush_q == FLUSH_LAST) begin
                        st_nxt = ST_FILL;
                    end else begin
                        flush_nxt = flush_q + FLUSH_W'(1);
                    end
                end
                ST_FILL: begin
                    if (data_count >= PREFILL_LVL) begin
                        st_nxt    = ST_RUN;
                        empty_nxt = '0;
                    end
                end
                ST_RUN: begin
                    if (empty) begin
                        // empty_q holds the number of prior consecutive empty cycles
                        if (empty_q == STARVE_LAST) begin
                            starve_evt = 1'b1;
                            st_nxt     = ST_FILL;
                            empty_nxt  = '0;
                        end else begin
                            empty_nxt = empty_q + EMPTY_W'(1);
                        end
                    end else begin
                        empty_nxt = '0;
                    end
                end
                default: begin
                    st_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and Moore outputs registered together so that the
    // outputs always change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            st_q        <= ST_IDLE;
            flush_q     <= '0;
            empty_q     <= '0;
            ovf_cnt     <= '0;
            starve_cnt  <= '0;
            fifo_in_en  <= 1'b0;
            fifo_out_en <= 1'b0;
            fifo_flush  <= 1'b0;
            running     <= 1'b0;
        end else begin
            st_q        <= st_nxt;
            flush_q     <= flush_nxt;
            empty_q     <= empty_nxt;
            ovf_cnt     <= cnt_step(ovf_cnt, ovf_evt, clear_cnt);
            starve_cnt  <= cnt_step(starve_cnt, starve_evt, clear_cnt);
            fifo_in_en  <= (st_nxt == ST_FILL) || (st_nxt == ST_RUN);
            fifo_out_en <= (st_nxt == ST_RUN);
            fifo_flush  <= (st_nxt == ST_FLUSH);
            running     <= (st_nxt == ST_RUN);
        end
    end

    assign state = 2'(st_q);

endmodule

// File: tb/tb_rx_iq_fifo_ctrl.sv
// Self-checking bench for rx_iq_fifo_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
// The counter width is reduced so that saturation is reachable quickly.
module tb_rx_iq_fifo_ctrl;

    localparam int unsigned COUNT_W       = 6;
    localparam int unsigned PREFILL       = 16;
    localparam int unsigned FLUSH_CYCLES  = 4;
    localparam int unsigned STARVE_CYCLES = 64;
    localparam int unsigned CNT_W         = 6;
    localparam int          CNT_MAX       = (1 << CNT_W) - 1;

    localparam int PH_IDLE  = 0;
    localparam int PH_FLUSH = 1;
    localparam int PH_FILL  = 2;
    localparam int PH_RUN   = 3;

    logic               clk = 1'b0;
    logic               rstn;
    logic               start;
    logic               stop;
    logic               clear_cnt;
    logic [COUNT_W-1:0] data_count;
    logic               full;
    logic               empty;
    logic               wren_in;
    logic               fifo_in_en;
    logic               fifo_out_en;
    logic               fifo_flush;
    logic [1:0]         state;
    logic               running;
    logic [CNT_W-1:0]   ovf_cnt;
    logic [CNT_W-1:0]   starve_cnt;

    always #5 clk = ~clk;

    rx_iq_fifo_ctrl #(
        .COUNT_W      (COUNT_W),
        .PREFILL      (PREFILL),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .STARVE_CYCLES(STARVE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .stop       (stop),
        .clear_cnt  (clear_cnt),
        .data_count (data_count),
        .full       (full),
        .empty      (empty),
        .wren_in    (wren_in),
        .fifo_in_en (fifo_in_en),
        .fifo_out_en(fifo_out_en),
        .fifo_flush (fifo_flush),
        .state      (state),
        .running    (running),
        .ovf_cnt    (ovf_cnt),
        .starve_cnt (starve_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase, remaining flush cycles, consecutive empties, event counts.
    int m_ph;
    int m_flush_left;
    int m_empties;
    int m_ovf;
    int m_starve;
    bit write_req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic quiet();
        start      = 1'b0;
        stop       = 1'b0;
        clear_cnt  = 1'b0;
        write_req  = 1'b0;
        full       = 1'b0;
        empty      = 1'b0;
        data_count = '0;
    endtask

    // Advance the model with the current inputs, clock once, compare all outputs.
    task automatic step();
        bit ovf;
        bit gate_open;
        gate_open = (m_ph == PH_FILL) || (m_ph == PH_RUN);
        wren_in   = write_req & gate_open;
        if (!rstn) begin
            m_ph = PH_IDLE; m_flush_left = 0; m_empties = 0; m_ovf = 0; m_starve = 0;
        end else begin
            ovf = wren_in && full && gate_open;
            if (stop) begin
                m_ph = PH_IDLE;
            end else if (ovf) begin
                m_ph = PH_FLUSH;
                m_flush_left = FLUSH_CYCLES;
                if (m_ovf < CNT_MAX) m_ovf++;
            end else begin
                case (m_ph)
                    PH_IDLE: if (start) begin
                        m_ph = PH_FLUSH;
                        m_flush_left = FLUSH_CYCLES;
                    end
                    PH_FLUSH: begin
                        m_flush_left--;
                        if (m_flush_left == 0) m_ph = PH_FILL;
                    end
                    PH_FILL: if (int'(data_count) >= int'(PREFILL)) begin
                        m_ph = PH_RUN;
                        m_empties = 0;
                    end
                    default: begin
                        if (empty) begin
                            m_empties++;
                            if (m_empties == int'(STARVE_CYCLES)) begin
                                if (m_starve < CNT_MAX) m_starve++;
                                m_ph = PH_FILL;
                            end
                        end else begin
                            m_empties = 0;
                        end
                    end
                endcase
            end
            if (clear_cnt) begin
                m_ovf = 0;
                m_starve = 0;
            end
        end
        @(posedge clk);
        #1;
        check("state", 32'(state), 32'(m_ph));
        check("running", 32'(running), 32'(m_ph == PH_RUN));
        check("fifo_in_en", 32'(fifo_in_en), 32'((m_ph == PH_FILL) || (m_ph == PH_RUN)));
        check("fifo_out_en", 32'(fifo_out_en), 32'(m_ph == PH_RUN));
        check("fifo_flush", 32'(fifo_flush), 32'(m_ph == PH_FLUSH));
        check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
        check("starve_cnt", 32'(starve_cnt), 32'(m_starve));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step with quiet inputs until the model reaches a phase (bounded).
    task automatic go_to(input int ph, input int dc);
        for (int i = 0; i < 16 && m_ph != ph; i++) begin
            data_count = COUNT_W'(dc);
            step();
        end
        check("go_to_phase", 32'(state), 32'(ph));
    endtask

    initial begin
        bit empty_mode;
        int burst_left;

        quiet();
        rstn = 1'b0;
        m_ph = PH_IDLE; m_flush_left = 0; m_empties = 0; m_ovf = 0; m_starve = 0;
        steps(2);
        rstn = 1'b1;
        steps(2);

        // Startup: four flush cycles, then FILL; a long wait just under the prefill level.
        start = 1'b1; step(); start = 1'b0;
        check("flush_first", 32'(fifo_flush), 32'd1);
        steps(3);
        check("flush_last", 32'(fifo_flush), 32'd1);
        step();
        check("fill_after_flush", 32'(state), 32'(PH_FILL));
        data_count = COUNT_W'(15);
        steps(100);
        check("fill_no_read", 32'(fifo_out_en), 32'd0);
        data_count = COUNT_W'(16);
        step();
        check("run_read", 32'(fifo_out_en), 32'd1);

        // Overflow in RUN, then recovery through flush and prefill.
        write_req = 1'b1; full = 1'b1; step();
        write_req = 1'b0; full = 1'b0;
        check("ovf_one", 32'(ovf_cnt), 32'd1);
        data_count = '0;
        steps(5);
        data_count = COUNT_W'(20);
        step();

        // Starvation after 64 empties, and a 63-empty run that must not trigger.
        empty = 1'b1;
        steps(64);
        check("starve_one", 32'(starve_cnt), 32'd1);
        empty = 1'b0;
        step();
        for (int r = 0; r < 2; r++) begin
            empty = 1'b1; steps(63);
            empty = 1'b0; step();
        end
        check("no_starve", 32'(starve_cnt), 32'd1);

        // Illegal full+empty with a write: overflow wins.
        write_req = 1'b1; full = 1'b1; empty = 1'b1; step();
        quiet();
        check("illegal_flags", 32'(state), 32'(PH_FLUSH));

        // stop priority, start+stop in IDLE, stop during FLUSH.
        stop = 1'b1; step(); stop = 1'b0;
        start = 1'b1; stop = 1'b1; step();
        check("start_stop_idle", 32'(state), 32'(PH_IDLE));
        stop = 1'b0; step(); start = 1'b0;
        stop = 1'b1; step(); stop = 1'b0;
        check("stop_flush", 32'(fifo_flush), 32'd0);

        // Drive ovf_cnt into saturation through repeated overflow in FILL.
        start = 1'b1; step(); start = 1'b0;
        for (int e = 0; e < CNT_MAX + 3; e++) begin
            go_to(PH_FILL, 0);
            write_req = 1'b1; full = 1'b1; step();
            write_req = 1'b0; full = 1'b0;
        end
        check("ovf_saturated", 32'(ovf_cnt), 32'(CNT_MAX));
        go_to(PH_FILL, 0);
        clear_cnt = 1'b1; write_req = 1'b1; full = 1'b1; step();
        quiet();
        check("clear_vs_ovf", 32'(ovf_cnt), 32'd0);
        check("clear_vs_ovf_state", 32'(state), 32'(PH_FLUSH));

        // clear_cnt while running leaves the state alone.
        go_to(PH_RUN, 30);
        clear_cnt = 1'b1; data_count = COUNT_W'(30); step(); clear_cnt = 1'b0;

        // Randomized traffic.
        empty_mode = 1'b0;
        burst_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (burst_left == 0) begin
                empty_mode = ~empty_mode;
                burst_left = empty_mode ? int'($urandom_range(1, 90)) : int'($urandom_range(1, 40));
            end
            burst_left--;
            rstn      = ($urandom_range(0, 399) != 0);
            start     = ($urandom_range(0, 29) == 0);
            stop      = ($urandom_range(0, 249) == 0);
            clear_cnt = ($urandom_range(0, 199) == 0);
            write_req = $urandom_range(0, 1) != 0;
            empty     = empty_mode;
            full      = !empty_mode && ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 499) == 0) begin
                full  = 1'b1;
                empty = 1'b1;
            end
            if ($urandom_range(0, 1) != 0) data_count = COUNT_W'($urandom_range(10, 22));
            else                           data_count = COUNT_W'($urandom_range(0, 63));
            step();
        end
        rstn = 1'b1;
        quiet();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_iq_fifo_ctrl.md
Name: rx_iq_fifo_ctrl

Overview:
Sequencing controller for the rx I/Q FIFO path.
- Drives the FIFO write-enable gate (fifo_in_en), read-enable gate (fifo_out_en) and flush (FIFO reset), using the FIFO fill level and flags.
- On start it flushes the FIFO, then prefills it to a mid-band level, so the downstream rate-matching read pacer starts in its nominal band.
- During operation it detects overflow and starvation, counts each event, and recovers automatically.

Parameters:
- COUNT_W, 6, width of the data_count input.
- PREFILL, 16, fill level (data_count >= PREFILL) at which reads are enabled.
- FLUSH_CYCLES, 4, number of cycles fifo_flush is held high (1..15).
- STARVE_CYCLES, 64, consecutive empty cycles in RUN that count as starvation (1..255).
- CNT_W, 16, width of the event counters.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to begin streaming.
- stop  in  1  single-cycle request to halt streaming.
- clear_cnt  in  1  synchronous clear of the event counters.
- data_count  in  COUNT_W  FIFO occupancy.
- full  in  1  FIFO full flag.
- empty  in  1  FIFO empty flag.
- wren_in  in  1  gated FIFO write strobe, as seen at the FIFO.
- fifo_in_en  out  1  write gate to the FIFO interface.
- fifo_out_en  out  1  read gate to the FIFO interface.
- fifo_flush  out  1  FIFO reset, active-high.
- state  out  2  current state: 0 IDLE, 1 FLUSH, 2 FILL, 3 RUN.
- running  out  1  high in RUN only.
- ovf_cnt  out  CNT_W  saturating overflow event count.
- starve_cnt  out  CNT_W  saturating starvation event count.

Behaviour:
- Reset (rstn=0 at a clk edge): state=IDLE, flush counter=0, empty-run counter=0, ovf_cnt=0, starve_cnt=0.
- All outputs are decoded from registered state, so every output is 0 in reset.
- Output decode (Moore):
  - IDLE: in_en=0, out_en=0, flush=0.
  - FLUSH: in_en=0, out_en=0, flush=1.
  - FILL: in_en=1, out_en=0, flush=0.
  - RUN: in_en=1, out_en=1, flush=0.
- All transitions take effect one clk after the condition is sampled.
- Priority order: stop > overflow > FLUSH/FILL exit > start. stop in any state -> IDLE.
- IDLE:
  - start=1 and stop=0 -> FLUSH, flush counter loaded 0.
  - start and stop together -> remain IDLE.
- FLUSH:
  - Flush counter increments each cycle.
  - When the counter reaches FLUSH_CYCLES-1 -> FILL. fifo_flush is therefore high for exactly FLUSH_CYCLES cycles.
  - start in FLUSH is ignored.
- FILL:
  - data_count >= PREFILL -> RUN, empty-run counter cleared.
  - No timeout; stays in FILL while input is absent.
  - wren_in & full in FILL is treated as overflow.
- RUN:
  - wren_in & full -> overflow event: ovf_cnt +1, next state FLUSH.
  - Otherwise, if empty=1, the empty-run counter increments. When it reaches STARVE_CYCLES-1 with empty still 1 -> starvation event: starve_cnt +1, next state FILL. Reads stop until the prefill level is met again.
  - empty=0 clears the empty-run counter.
  - start in RUN is ignored.
- full and empty are mutually exclusive. If both are asserted (illegal), overflow wins.
- Counters saturate at all-ones and do not wrap.
- clear_cnt zeroes both counters. If clear_cnt coincides with an increment, the result is 0.
- clear_cnt has no effect on state.
- Reset mid-operation (any state) -> IDLE next edge. Outputs drop within the same cycle as state.
- Throughput: once in RUN, no bubbles are introduced by the controller.

Test Plan:
- Reset, then start pulse: state sequence IDLE -> FLUSH ×4 cycles (fifo_flush=1) -> FILL. Drive data_count to 16 -> RUN next cycle, with in_en=1 and out_en=1.
- In FILL with data_count=15 for 100 cycles: out_en stays 0. Step to 16: out_en=1 one cycle later.
- In RUN, wren_in=1 with full=1 for one cycle: ovf_cnt 0 -> 1 and state -> FLUSH. Next fifo_flush lasts 4 cycles, then FILL.
- In RUN, hold empty=1 for 64 cycles: starve_cnt=1 and state=FILL. Hold empty for 63 cycles, then empty=0: no event, counter restarts.
- stop and start in the same cycle from IDLE: remains IDLE. stop during FLUSH: IDLE next cycle, fifo_flush=0.
- Preload ovf_cnt to 0xFFFF via repeated events: a further overflow keeps 0xFFFF. clear_cnt coincident with an overflow -> ovf_cnt=0 while state still goes to FLUSH.
